// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit RAM behind a req/ack handshake.
// A request is latched in IDLE, waits WAIT_CYCLES extra cycles in BUSY,
// commits the access on the last BUSY edge and presents a one-cycle ack in RESP.
// Word and sign-extended byte (lb/sb) accesses; misaligned word access flags err.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              isbyte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic                we_r, isbyte_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic                ack_r, err_r;
  logic [31:0]         rdata_r;
  logic                latch_s, access_s;
  logic                misalign_s, mem_we_s;
  logic                ack_nxt_s, err_nxt_s;
  logic [31:0]         rdata_nxt_s, word_s, wr_word_s;
  logic [ADDR_W-3:0]   idx_s;
  logic [1:0]          lane_s;
  logic [31:0]         mem_r [DEPTH];

  // Select byte lane 'lane' of 'word' and sign-extend it (lb semantics).
  function automatic logic [31:0] lb_extend(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return {{24{b[7]}}, b};
  endfunction

  // Replace byte lane 'lane' of 'word' with 'b', keeping the other lanes.
  function automatic logic [31:0] sb_merge(input logic [31:0] word, input logic [7:0] b,
                                           input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = word;
    endcase
    return r;
  endfunction

  assign idx_s      = addr_r[ADDR_W-1:2];
  assign lane_s     = addr_r[1:0];
  assign word_s     = mem_r[idx_s];
  assign misalign_s = (isbyte_r == 1'b0) && (lane_s != 2'd0);
  assign mem_we_s   = access_s && we_r && !misalign_s;
  assign wr_word_s  = isbyte_r ? sb_merge(word_s, wdata_r[7:0], lane_s) : wdata_r;

  // Next-state, wait counter and response computation for the handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          latch_s     = 1'b1;
          cnt_nxt_s   = 4'(WAIT_CYCLES);
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          access_s    = 1'b1;
          state_nxt_s = RESP;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase

    ack_nxt_s   = access_s;
    err_nxt_s   = access_s && misalign_s;
    rdata_nxt_s = 32'h0000_0000;
    if (access_s && !we_r && !misalign_s) begin
      rdata_nxt_s = isbyte_r ? lb_extend(word_s, lane_s) : word_s;
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end
  end

  // State, counter, latched request and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      isbyte_r <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        we_r     <= we;
        isbyte_r <= isbyte;
        addr_r   <= addr;
        wdata_r  <= wdata;
      end
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      rdata_r <= rdata_nxt_s;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= wr_word_s;
    end
  end

  assign ack   = ack_r;
  assign rdata = rdata_r;
  assign err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven transactions with a
// scoreboard queue, plus hand-written back-to-back, reset and zero-wait sequences.
module tb_mem_responder;

  logic        clk, rst;
  logic        req2, req0, we, isbyte;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        ack2, ack0, err2, err0;
  logic [31:0] rdata2, rdata0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          we;
    bit          isbyte;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req2), .we(we), .isbyte(isbyte), .addr(addr),
    .wdata(wdata), .ack(ack2), .rdata(rdata2), .err(err2)
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .isbyte(isbyte), .addr(addr),
    .wdata(wdata), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one transaction from a negedge, wait for ack, check latency and data.
  task automatic run_txn(input bit use0, input bit t_we, input bit t_byte,
                         input logic [9:0] t_addr, input logic [31:0] t_wdata,
                         input logic [31:0] e_rdata, input bit e_err, input string name);
    int  lat;
    bit  seen;
    exp_t e;
    exp_q.push_back('{rdata: e_rdata, err: e_err});
    we = t_we; isbyte = t_byte; addr = t_addr; wdata = t_wdata;
    if (use0) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((use0 ? ack0 : ack2) == 1'b1) seen = 1'b1;
    end
    req0 = 1'b0; req2 = 1'b0;
    check32({name, "_ack_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check32({name, "_latency"}, lat, use0 ? 32'd1 : 32'd3);
      e = exp_q.pop_front();
      check32({name, "_rdata"}, use0 ? rdata0 : rdata2, e.rdata);
      check32({name, "_err"}, {31'd0, use0 ? err0 : err2}, {31'd0, e.err});
      @(negedge clk);
      check32({name, "_ack_drop"}, {31'd0, use0 ? ack0 : ack2}, 32'd0);
      check32({name, "_rdata_idle"}, use0 ? rdata0 : rdata2, 32'd0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  vec_t vecs[$];

  initial begin
    int   cnt_ack, last_c, consec;
    bit   prev_ack;
    exp_t e;

    vecs = '{
      '{1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0},
      '{1'b0, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 1'b0, 10'h020, 32'h11223344, 32'h0000_0000, 1'b0},
      '{1'b1, 1'b1, 10'h022, 32'h000000AA, 32'h0000_0000, 1'b0},
      '{1'b0, 1'b0, 10'h020, 32'h0,        32'h11AA3344, 1'b0},
      '{1'b0, 1'b1, 10'h023, 32'h0,        32'h00000011, 1'b0},
      '{1'b0, 1'b1, 10'h022, 32'h0,        32'hFFFFFFAA, 1'b0},
      '{1'b0, 1'b1, 10'h021, 32'h0,        32'h00000033, 1'b0},
      '{1'b0, 1'b1, 10'h010, 32'h0,        32'hFFFFFFEF, 1'b0},
      '{1'b1, 1'b0, 10'h004, 32'h55667788, 32'h0000_0000, 1'b0},
      '{1'b1, 1'b0, 10'h006, 32'h12345678, 32'h0000_0000, 1'b1},
      '{1'b0, 1'b0, 10'h004, 32'h0,        32'h55667788, 1'b0},
      '{1'b0, 1'b0, 10'h005, 32'h0,        32'h0000_0000, 1'b1},
      '{1'b1, 1'b0, 10'h3FC, 32'hA5A5A5A5, 32'h0000_0000, 1'b0},
      '{1'b1, 1'b1, 10'h3FF, 32'h1234567F, 32'h0000_0000, 1'b0},
      '{1'b0, 1'b1, 10'h3FF, 32'h0,        32'h0000007F, 1'b0},
      '{1'b0, 1'b0, 10'h3FC, 32'h0,        32'h7FA5A5A5, 1'b0},
      '{1'b1, 1'b0, 10'h030, 32'h00000000, 32'h0000_0000, 1'b0}
    };

    rst = 1'b0; req2 = 1'b0; req0 = 1'b0; we = 1'b0; isbyte = 1'b0;
    addr = 10'h000; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check32("reset_ack", {31'd0, ack2}, 32'd0);
    check32("reset_rdata", rdata2, 32'd0);
    check32("reset_err", {31'd0, err2}, 32'd0);
    check32("reset_ack0", {31'd0, ack0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(1'b0, vecs[i].we, vecs[i].isbyte, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Back-to-back: req held high across two word reads.
    cnt_ack = 0; last_c = 0; consec = 0; prev_ack = 1'b0;
    we = 1'b0; isbyte = 1'b0; addr = 10'h010; req2 = 1'b1;
    exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack2 && prev_ack) consec++;
      prev_ack = ack2;
      if (ack2) begin
        cnt_ack++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check32("b2b_rdata", rdata2, e.rdata);
          check32("b2b_err", {31'd0, err2}, {31'd0, e.err});
        end
        if (cnt_ack == 1) begin
          addr = 10'h020;
          exp_q.push_back('{rdata: 32'h11AA3344, err: 1'b0});
        end else begin
          req2 = 1'b0;
          check32("b2b_spacing_ok", {31'd0, (c - last_c) >= 4}, 32'd1);
        end
        last_c = c;
      end
    end
    req2 = 1'b0;
    check32("b2b_ack_count", cnt_ack, 32'd2);
    check32("b2b_no_consecutive_ack", consec, 32'd0);
    exp_q.delete();

    // Reset while a write to 0x030 is still in BUSY: the write is discarded.
    we = 1'b1; isbyte = 1'b0; addr = 10'h030; wdata = 32'hCAFEF00D; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req2 = 1'b0;
    #1;
    check32("rst_busy_ack", {31'd0, ack2}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 1'b0, 10'h030, 32'h0, 32'h0000_0000, 1'b0, "rst_busy_read");

    // Reset during RESP: ack must fall immediately, not at the next edge.
    we = 1'b0; isbyte = 1'b0; addr = 10'h010; req2 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    check32("rst_resp_ack_before", {31'd0, ack2}, 32'd1);
    rst = 1'b0;
    #1;
    check32("rst_resp_ack_after", {31'd0, ack2}, 32'd0);
    check32("rst_resp_rdata_after", rdata2, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero wait states.
    run_txn(1'b1, 1'b1, 1'b0, 10'h040, 32'h13579BDF, 32'h0000_0000, 1'b0, "w0_write");
    run_txn(1'b1, 1'b0, 1'b0, 10'h040, 32'h0,        32'h13579BDF, 1'b0, "w0_read");
    run_txn(1'b1, 1'b0, 1'b1, 10'h041, 32'h0,        32'hFFFFFF9B, 1'b0, "w0_lb");
    run_txn(1'b1, 1'b0, 1'b0, 10'h042, 32'h0,        32'h0000_0000, 1'b1, "w0_misalign");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
